// File: rtl/list_source.sv
// List transmitter: host-loaded scratchpad streamed out as valid/ready beats.
// Optional o_last output is enabled with `define LIST_SOURCE_LAST_EN.
module list_source #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_start,
    input  logic [AW:0]   i_len,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
`ifdef LIST_SOURCE_LAST_EN
    output logic          o_last,
`endif
    input  logic          i_ready
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   idx, idx_d;
    logic [DW-1:0] data_d;
    logic          valid_d;
    logic          done_d;
    logic [AW:0]   len_eff;
    logic          hs;
`ifdef LIST_SOURCE_LAST_EN
    logic          last_d;
`endif

    logic [DW-1:0] mem [DEPTH];

    assign len_eff = (i_len > DEPTH_L) ? DEPTH_L : i_len;
    assign hs      = o_valid && i_ready;
    assign o_busy  = (state_q == RUN);

    // Scratchpad is locked while a list is in flight; never reset.
    always_ff @(posedge CLK) begin
        if (i_wr_en && state_q == IDLE)
            mem[i_wr_addr] <= i_wr_data;
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx;
        data_d  = o_data;
        valid_d = o_valid;
        done_d  = 1'b0;
`ifdef LIST_SOURCE_LAST_EN
        last_d  = o_last;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    len_d = len_eff;
                    if (len_eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // mem read here sees the pre-write value of a same-cycle write
                        data_d  = mem[0];
                        valid_d = 1'b1;
                        idx_d   = (AW+1)'(1);
                        state_d = RUN;
`ifdef LIST_SOURCE_LAST_EN
                        last_d  = (len_eff == (AW+1)'(1));
`endif
                    end
                end
            end
            RUN: begin
                if (hs) begin
                    if (idx < len_q) begin
                        data_d = mem[idx[AW-1:0]];
                        idx_d  = idx + 1'b1;
`ifdef LIST_SOURCE_LAST_EN
                        last_d = (idx == len_q - 1'b1);
`endif
                    end else begin
                        valid_d = 1'b0;
                        data_d  = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
`ifdef LIST_SOURCE_LAST_EN
                        last_d  = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx     <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_done  <= 1'b0;
`ifdef LIST_SOURCE_LAST_EN
            o_last  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx     <= idx_d;
            o_data  <= data_d;
            o_valid <= valid_d;
            o_done  <= done_d;
`ifdef LIST_SOURCE_LAST_EN
            o_last  <= last_d;
`endif
        end
    end

endmodule

// File: doc/list_source.md
# list_source

Transmitter end of the list-element valid/ready stream. It holds up to DEPTH elements in an internal scratchpad, which a host loads through a simple write port. On a start command it streams elements 0..len-1 out as valid/ready beats with full backpressure support, at one beat per cycle when the downstream is always ready. It sits upstream of the list skid buffers and feeds list data into the stream fabric.

## Interface
- DW, 32, element/data width
- DEPTH, 16, scratchpad entries; power of two, ≥2
- AW, $clog2(DEPTH), scratchpad address width (derived, not overridden)

- CLK  input  1  clock
- RESET  input  1  reset, synchronous, active-high
- i_wr_en  input  1  scratchpad write strobe
- i_wr_addr  input  AW  scratchpad write address
- i_wr_data  input  DW  scratchpad write data
- i_start  input  1  start command, one-cycle qualifier
- i_len  input  AW+1  number of elements to send, 0..DEPTH
- o_busy  output  1  high while a list is being streamed
- o_done  output  1  one-cycle pulse at end of list
- o_valid  output  1  stream beat valid
- o_data  output  DW  stream beat data
- o_last  output  1  final beat of list (LIST_SOURCE_LAST_EN only)
- i_ready  input  1  downstream ready

## Operation
- States:
  - IDLE: o_busy=0.
  - RUN: o_busy=1.
- Register `len_q` (AW+1 bits) holds the effective length; register `idx` (AW+1 bits) is the next-read pointer.
- Scratchpad writes:
  - Accepted when i_wr_en=1 and state is IDLE.
  - Ignored in RUN. The scratchpad is locked while streaming.
- Start handling:
  - i_start is accepted only in IDLE. It is ignored in RUN, including when it coincides with the last handshake.
  - Effective length: len_q = min(i_len, DEPTH).
- Start with len_q=0: stay in IDLE, no beats sent, o_done pulses on the next cycle.
- Start with len_q>0, at the same edge:
  - o_data<=mem[0], o_valid<=1, idx<=1, state goes to RUN.
- Handshake = o_valid && i_ready. On each handshake in RUN:
  - If idx<len_q: o_data<=mem[idx], o_valid stays 1, idx<=idx+1.
  - Otherwise: o_valid<=0, o_data<=0, state goes to IDLE, o_done<=1 for one cycle.
- Backpressure rule: while o_valid=1 and i_ready=0, o_valid and o_data hold stable. Never drop or reorder data.
- o_valid never deasserts mid-list except at the final handshake.
- RESET mid-operation:
  - Next cycle: state IDLE, o_valid=0, o_done=0.
  - Scratchpad contents are not cleared.
  - No partial list resumes after reset.

## Timing
- Reset values: o_busy=0, o_done=0, o_valid=0, o_data=0, o_last=0, idx=0, len_q=0.
- Latency: first beat is valid in the cycle after i_start is accepted.
- Throughput: with i_ready held high, len beats occupy len consecutive cycles.
  - o_done and o_busy=0 occur in the cycle after the final handshake.
- A write in the same cycle as an accepted start:
  - The write lands.
  - The beat loaded by the start reads the pre-write value of mem[0].
- o_busy is a registered state decode; it rises in the cycle o_valid first rises.

## Configuration
- Macro: LIST_SOURCE_LAST_EN.
- Defined:
  - o_last port exists.
  - o_last is registered alongside o_data; it is 1 exactly on the beat carrying element len_q-1.
  - o_last is 0 otherwise and at reset.
- Not defined: o_last port is absent, and no logic is generated for it.

## Test plan
- Load mem[0..3]=0xA0..0xA3, start len=4, i_ready=1 → beats A0,A1,A2,A3 on 4 consecutive cycles starting 1 cycle after start; o_done pulse the next cycle; o_last on A3 (LAST_EN).
- Same list with i_ready toggling 1,0,0,1,... → o_data holds stable through stalls; exactly 4 beats in order; no duplicates.
- Start len=0 → no o_valid; o_done pulses 1 cycle later; o_busy stays 0.
- Start len=DEPTH+5 → exactly DEPTH beats (0..DEPTH-1), then o_done.
- During RUN: write mem[1]=0xFF, and assert i_start with len=2 → both ignored; original mem[1] is streamed; list length unchanged.
- RESET asserted after 2 of 4 beats → o_valid=0 next cycle, o_busy=0, no o_done. A fresh start len=4 then streams the original 4 values from element 0.
